// File: rtl/round_pkg.sv
// Shared constants for the round timer controller and its timer counter:
// FSM state encodings and the default game timing parameters.
package round_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_RUN     = 3'd2,
    S_HIT     = 3'd3,
    S_TIMEOUT = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  localparam logic [15:0] DEF_MAXCOUNT   = 16'd35264;
  localparam int          DEF_TICK_DIV   = 50;
  localparam int          DEF_NUM_ROUNDS = 8;
  localparam int          DEF_SCORE_W    = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-DIV counter that produces a one-cycle tick on its last count.
// Clear has priority over enable; the tick is combinational from the count.
module tick_prescaler #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i & (cnt_q == LAST);

endmodule

// File: rtl/round_timer_ctrl.sv
// Sequences the round timer counter across a multi-round game: arms it each
// round, paces it with a prescaled enable, and tracks round number and score.
module round_timer_ctrl
  import round_pkg::*;
#(
  parameter logic [15:0] MAXCOUNT   = DEF_MAXCOUNT,
  parameter int          TICK_DIV   = DEF_TICK_DIV,
  parameter int          NUM_ROUNDS = DEF_NUM_ROUNDS,
  parameter int          SCORE_W    = DEF_SCORE_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               hit,
  input  logic [15:0]        count,
  output logic               go,
  output logic               en,
  output logic [2:0]         state_o,
  output logic [3:0]         round,
  output logic [SCORE_W-1:0] score,
  output logic               round_done,
  output logic               game_over
);

  localparam logic [3:0]         LAST_ROUND = 4'(NUM_ROUNDS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

  state_e             state_q, state_d;
  logic [3:0]         round_q, round_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               start_q;
  logic               start_rise;
  logic               go_q, go_d;
  logic               en_q, en_d;
  logic               round_done_q, round_done_d;
  logic               game_over_q, game_over_d;
  logic               tick;

  assign start_rise = start & ~start_q;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (resetn),
    .clr_i  (state_q == S_ARM),
    .en_i   (state_q == S_RUN),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    score_d = score_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_rise) begin
          round_d = '0;
          score_d = '0;
          state_d = S_ARM;
        end
      end
      S_ARM: state_d = S_RUN;
      S_RUN: begin
        // A hit in the expiry cycle still counts as a hit.
        if (hit) begin
          state_d = S_HIT;
        end else if (count == MAXCOUNT) begin
          state_d = S_TIMEOUT;
        end
      end
      S_HIT, S_TIMEOUT: begin
        if (state_q == S_HIT && score_q != SCORE_MAX) begin
          score_d = score_q + SCORE_W'(1);
        end
        if (round_q == LAST_ROUND) begin
          state_d = S_DONE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = S_ARM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output flops are loaded from the state being entered, so they line up
  // with state_q in the following cycle.
  always_comb begin
    go_d         = (state_d == S_ARM);
    en_d         = (state_q == S_RUN) && (state_d == S_RUN) && tick;
    round_done_d = (state_d == S_HIT) || (state_d == S_TIMEOUT);
    game_over_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      round_q      <= '0;
      score_q      <= '0;
      start_q      <= 1'b0;
      go_q         <= 1'b0;
      en_q         <= 1'b0;
      round_done_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      score_q      <= score_d;
      start_q      <= start;
      go_q         <= go_d;
      en_q         <= en_d;
      round_done_q <= round_done_d;
      game_over_q  <= game_over_d;
    end
  end

  assign go         = go_q;
  assign en         = en_q;
  assign state_o    = state_q;
  assign round      = round_q;
  assign score      = score_q;
  assign round_done = round_done_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl driving a behavioural timer counter;
// instance a plays a 2-round game, instance b a 6-round game for saturation.
module tb_round_timer_ctrl;

  localparam logic [15:0] MAXC = 16'd5;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_a, hit_a, start_b, hit_b;
  logic [15:0] count_a, count_b;
  logic        go_a, en_a, round_done_a, game_over_a;
  logic        go_b, en_b, round_done_b, game_over_b;
  logic [2:0]  state_a, state_b;
  logic [3:0]  round_a, round_b;
  logic [1:0]  score_a, score_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  round_timer_ctrl #(
    .MAXCOUNT (MAXC), .TICK_DIV (2), .NUM_ROUNDS (2), .SCORE_W (2)
  ) dut_a (
    .clk (clk), .resetn (resetn), .start (start_a), .hit (hit_a),
    .count (count_a), .go (go_a), .en (en_a), .state_o (state_a),
    .round (round_a), .score (score_a), .round_done (round_done_a),
    .game_over (game_over_a)
  );

  round_timer_ctrl #(
    .MAXCOUNT (MAXC), .TICK_DIV (2), .NUM_ROUNDS (6), .SCORE_W (2)
  ) dut_b (
    .clk (clk), .resetn (resetn), .start (start_b), .hit (hit_b),
    .count (count_b), .go (go_b), .en (en_b), .state_o (state_b),
    .round (round_b), .score (score_b), .round_done (round_done_b),
    .game_over (game_over_b)
  );

  // Timer counter: clears the cycle after go, counts on en, stops at MAXCOUNT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) count_a <= '0;
    else if (go_a) count_a <= '0;
    else if (en_a && count_a != MAXC) count_a <= count_a + 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) count_b <= '0;
    else if (go_b) count_b <= '0;
    else if (en_b && count_b != MAXC) count_b <= count_b + 16'd1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; start_a = 1'b0; hit_a = 1'b0; start_b = 1'b0; hit_b = 1'b0;
    repeat (3) step();
    n_checks++; if (state_a !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", state_a); end
    n_checks++; if (go_a !== 1'b0) begin n_fail++; $display("FAIL reset_go: got %0b exp 0", go_a); end
    n_checks++; if (en_a !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %0b exp 0", en_a); end
    n_checks++; if (round_a !== 4'd0) begin n_fail++; $display("FAIL reset_round: got %0d exp 0", round_a); end
    n_checks++; if (score_a !== 2'd0) begin n_fail++; $display("FAIL reset_score: got %0d exp 0", score_a); end
    n_checks++; if (round_done_a !== 1'b0) begin n_fail++; $display("FAIL reset_round_done: got %0b exp 0", round_done_a); end
    n_checks++; if (game_over_a !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %0b exp 0", game_over_a); end
    n_checks++; if (state_b !== 3'd0) begin n_fail++; $display("FAIL reset_state_b: got %0d exp 0", state_b); end
    resetn = 1'b1;
    step();
    n_checks++; if (state_a !== 3'd0) begin n_fail++; $display("FAIL idle_after_reset: got %0d exp 0", state_a); end
  endtask

  task automatic test_start_timeout();
    logic [2:0]  exp_state [13] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
                                    3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    logic        exp_en    [13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] exp_cnt   [13] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd2,
                                    16'd2, 16'd3, 16'd3, 16'd4, 16'd4, 16'd5};
    int go_seen = 0;
    start_a = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      if (go_a === 1'b1) go_seen++;
      n_checks++; if (state_a !== exp_state[i]) begin n_fail++; $display("FAIL seq_state[%0d]: got %0d exp %0d", i, state_a, exp_state[i]); end
      n_checks++; if (en_a !== exp_en[i]) begin n_fail++; $display("FAIL seq_en[%0d]: got %0b exp %0b", i, en_a, exp_en[i]); end
      n_checks++; if (count_a !== exp_cnt[i]) begin n_fail++; $display("FAIL seq_count[%0d]: got %0d exp %0d", i, count_a, exp_cnt[i]); end
      if (i == 9) start_a = 1'b0;
    end
    n_checks++; if (go_seen != 1) begin n_fail++; $display("FAIL single_go: got %0d pulses exp 1", go_seen); end
    step();
    n_checks++; if (state_a !== 3'd4) begin n_fail++; $display("FAIL timeout_state: got %0d exp 4", state_a); end
    n_checks++; if (round_done_a !== 1'b1) begin n_fail++; $display("FAIL timeout_round_done: got %0b exp 1", round_done_a); end
    n_checks++; if (en_a !== 1'b0) begin n_fail++; $display("FAIL timeout_en: got %0b exp 0", en_a); end
    step();
    n_checks++; if (state_a !== 3'd1) begin n_fail++; $display("FAIL rearm_state: got %0d exp 1", state_a); end
    n_checks++; if (go_a !== 1'b1) begin n_fail++; $display("FAIL rearm_go: got %0b exp 1", go_a); end
    n_checks++; if (round_a !== 4'd1) begin n_fail++; $display("FAIL rearm_round: got %0d exp 1", round_a); end
    n_checks++; if (score_a !== 2'd0) begin n_fail++; $display("FAIL rearm_score: got %0d exp 0", score_a); end
    n_checks++; if (round_done_a !== 1'b0) begin n_fail++; $display("FAIL round_done_width: got %0b exp 0", round_done_a); end
    repeat (12) step();
    n_checks++; if (count_a !== 16'd5) begin n_fail++; $display("FAIL r1_count: got %0d exp 5", count_a); end
    step();
    n_checks++; if (state_a !== 3'd4) begin n_fail++; $display("FAIL r1_timeout_state: got %0d exp 4", state_a); end
    step();
    n_checks++; if (state_a !== 3'd5) begin n_fail++; $display("FAIL done_state: got %0d exp 5", state_a); end
    n_checks++; if (game_over_a !== 1'b1) begin n_fail++; $display("FAIL done_game_over: got %0b exp 1", game_over_a); end
    n_checks++; if (round_a !== 4'd1) begin n_fail++; $display("FAIL done_round: got %0d exp 1", round_a); end
    n_checks++; if (round_done_a !== 1'b0) begin n_fail++; $display("FAIL done_round_done: got %0b exp 0", round_done_a); end
  endtask

  task automatic test_hit();
    start_a = 1'b1;
    step();
    n_checks++; if (state_a !== 3'd1) begin n_fail++; $display("FAIL restart_state: got %0d exp 1", state_a); end
    n_checks++; if (game_over_a !== 1'b0) begin n_fail++; $display("FAIL restart_game_over: got %0b exp 0", game_over_a); end
    n_checks++; if (round_a !== 4'd0) begin n_fail++; $display("FAIL restart_round: got %0d exp 0", round_a); end
    repeat (6) step();
    n_checks++; if (count_a !== 16'd2) begin n_fail++; $display("FAIL hit_count: got %0d exp 2", count_a); end
    hit_a = 1'b1;
    step();
    hit_a = 1'b0; start_a = 1'b0;
    n_checks++; if (state_a !== 3'd3) begin n_fail++; $display("FAIL hit_state: got %0d exp 3", state_a); end
    n_checks++; if (round_done_a !== 1'b1) begin n_fail++; $display("FAIL hit_round_done: got %0b exp 1", round_done_a); end
    step();
    n_checks++; if (state_a !== 3'd1) begin n_fail++; $display("FAIL hit_rearm: got %0d exp 1", state_a); end
    n_checks++; if (score_a !== 2'd1) begin n_fail++; $display("FAIL hit_score: got %0d exp 1", score_a); end
    n_checks++; if (round_a !== 4'd1) begin n_fail++; $display("FAIL hit_round: got %0d exp 1", round_a); end
    n_checks++; if (count_a !== 16'd2) begin n_fail++; $display("FAIL count_held_in_arm: got %0d exp 2", count_a); end
    step();
    n_checks++; if (count_a !== 16'd0) begin n_fail++; $display("FAIL count_cleared: got %0d exp 0", count_a); end
    n_checks++; if (go_a !== 1'b0) begin n_fail++; $display("FAIL go_drop: got %0b exp 0", go_a); end
  endtask

  task automatic test_hit_at_expiry();
    repeat (11) step();
    n_checks++; if (count_a !== 16'd5) begin n_fail++; $display("FAIL expiry_count: got %0d exp 5", count_a); end
    hit_a = 1'b1;
    step();
    hit_a = 1'b0;
    n_checks++; if (state_a !== 3'd3) begin n_fail++; $display("FAIL hit_priority: got %0d exp 3", state_a); end
    step();
    n_checks++; if (state_a !== 3'd5) begin n_fail++; $display("FAIL hit_done_state: got %0d exp 5", state_a); end
    n_checks++; if (score_a !== 2'd2) begin n_fail++; $display("FAIL hit_done_score: got %0d exp 2", score_a); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_score [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    start_b = 1'b1;
    step();
    n_checks++; if (state_b !== 3'd1) begin n_fail++; $display("FAIL sat_arm: got %0d exp 1", state_b); end
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++; if (state_b !== 3'd2) begin n_fail++; $display("FAIL sat_run[%0d]: got %0d exp 2", k, state_b); end
      hit_b = 1'b1;
      step();
      hit_b = 1'b0; start_b = 1'b0;
      n_checks++; if (round_done_b !== 1'b1) begin n_fail++; $display("FAIL sat_round_done[%0d]: got %0b exp 1", k, round_done_b); end
      step();
      n_checks++; if (score_b !== exp_score[k]) begin n_fail++; $display("FAIL sat_score[%0d]: got %0d exp %0d", k, score_b, exp_score[k]); end
      n_checks++; if (state_b !== ((k == 5) ? 3'd5 : 3'd1)) begin n_fail++; $display("FAIL sat_next_state[%0d]: got %0d", k, state_b); end
      n_checks++; if (round_b !== ((k == 5) ? 4'd5 : 4'(k + 1))) begin n_fail++; $display("FAIL sat_round[%0d]: got %0d", k, round_b); end
    end
  endtask

  task automatic test_async_reset();
    start_a = 1'b1;
    step();
    n_checks++; if (state_a !== 3'd1) begin n_fail++; $display("FAIL done_restart_state: got %0d exp 1", state_a); end
    n_checks++; if (score_a !== 2'd0) begin n_fail++; $display("FAIL done_restart_score: got %0d exp 0", score_a); end
    n_checks++; if (round_a !== 4'd0) begin n_fail++; $display("FAIL done_restart_round: got %0d exp 0", round_a); end
    repeat (4) step();
    n_checks++; if (state_a !== 3'd2) begin n_fail++; $display("FAIL pre_reset_run: got %0d exp 2", state_a); end
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (state_a !== 3'd0) begin n_fail++; $display("FAIL async_state: got %0d exp 0", state_a); end
    n_checks++; if (go_a !== 1'b0 || en_a !== 1'b0) begin n_fail++; $display("FAIL async_go_en: got %0b%0b exp 00", go_a, en_a); end
    n_checks++; if (round_done_a !== 1'b0) begin n_fail++; $display("FAIL async_round_done: got %0b exp 0", round_done_a); end
    start_a = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (state_a !== 3'd0 || round_done_a !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle[%0d]: got state %0d rd %0b exp 0 0", i, state_a, round_done_a); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_start_timeout();
    test_hit();
    test_hit_at_expiry();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
